// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: 1-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// Define SEQ_ALU_DIV_EN to add the iterative restoring divider on opcode 1011.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [2:0]       dbg_state
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1011;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
`ifdef SEQ_ALU_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [SHAMT_W:0]     cnt_q;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     exec_res;
  logic [WIDTH:0]       mul_acc;
  logic                 iter_done;

  // Handshake: Start is sampled only in IDLE; Busy covers every non-IDLE cycle,
  // Done is a one-cycle pulse in the last Busy cycle when results are valid.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign iter_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_nxt = state;
    Busy      = (state != S_IDLE);
    Done      = (state == S_DONE);
    dbg_state = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (ALUControl == OP_MUL) state_nxt = S_MUL;
`ifdef SEQ_ALU_DIV_EN
          else if (ALUControl == OP_DIV && B != '0) state_nxt = S_DIV;
`endif
          else state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_DONE;
      S_MUL:  if (iter_done) state_nxt = S_DONE;
`ifdef SEQ_ALU_DIV_EN
      S_DIV:  if (iter_done) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign shamt = b_q[SHAMT_W-1:0];

  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_ADD: exec_res = a_q + b_q;
      OP_SUB: exec_res = a_q - b_q;
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_NOR: exec_res = ~(a_q | b_q);
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SLL: exec_res = a_q << shamt;
      OP_SRL: exec_res = a_q >> shamt;
      OP_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SRA: exec_res = $signed(a_q) >>> shamt;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: exec_res = '1;  // only reaches EXEC on divide-by-zero
`endif
      default: exec_res = '0;
    endcase
  end

  // Multiplier in prod_q low half, partial product accumulates in the high half.
  assign mul_acc = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : '0)};

`ifdef SEQ_ALU_DIV_EN
  // Remainder in prod_q high half, dividend shifts out of / quotient into the low half.
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_sh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, b_q});
  assign div_sub = div_sh - {1'b0, b_q};
  assign div_rem = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q   <= ALUControl;
            a_q    <= A;
            b_q    <= B;
            cnt_q  <= '0;
            prod_q <= {{WIDTH{1'b0}}, B};
`ifdef SEQ_ALU_DIV_EN
            if (ALUControl == OP_DIV) prod_q <= {{WIDTH{1'b0}}, A};
`endif
          end
        end
        S_EXEC: begin
          ALUResult <= exec_res;
          Zero      <= (exec_res == '0);
`ifdef SEQ_ALU_DIV_EN
          if (op_q == OP_DIV) begin
            Lo <= '1;
            Hi <= a_q;
          end
`endif
        end
        S_MUL: begin
          if (!iter_done) begin
            prod_q <= {mul_acc, prod_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            Hi        <= prod_q[2*WIDTH-1:WIDTH];
            Lo        <= prod_q[WIDTH-1:0];
            ALUResult <= prod_q[WIDTH-1:0];
            Zero      <= (prod_q[WIDTH-1:0] == '0);
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          if (!iter_done) begin
            prod_q <= {div_rem, prod_q[WIDTH-2:0], div_ge};
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            Hi        <= prod_q[2*WIDTH-1:WIDTH];
            Lo        <= prod_q[WIDTH-1:0];
            ALUResult <= prod_q[WIDTH-1:0];
            Zero      <= (prod_q[WIDTH-1:0] == '0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results, negedge monitor pops on Done.
module tb_seq_alu;
  localparam int W  = 32;
  localparam int EW = 32 + W + 1 + W + W;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [3:0]   ALUControl;
  logic [W-1:0] A, B;
  logic         Busy, Done, Zero;
  logic [W-1:0] ALUResult, Hi, Lo;
  logic [2:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [W-1:0]  m_hi, m_lo;

  seq_alu #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .ALUResult(ALUResult),
    .Zero(Zero), .Hi(Hi), .Lo(Lo), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: plain arithmetic on the architectural rules
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res);
    logic [$clog2(W)-1:0] sh;
    logic [2*W-1:0] p;
    sh  = b[$clog2(W)-1:0];
    res = '0;
    case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = ~(a | b);
      4'd5:  res = a ^ b;
      4'd6:  res = a << sh;
      4'd7:  res = a >> sh;
      4'd8:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  res = a[W-1] ? ~((~a) >> sh) : (a >> sh);
      4'd10: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
        res = m_lo;
      end
`ifdef SEQ_ALU_DIV_EN
      4'd11: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        res = m_lo;
      end
`endif
      default: res = '0;
    endcase
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge Clk);
    while (Busy && k < 200) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: Busy still %0b after %0d cycles, required 0", Busy, k);
    end
  endtask

  // driver: launch one op and push its expected completion
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    int lat;
    int n;
    wait_idle();
    ALUControl = op;
    A = a;
    B = b;
    Start = 1'b1;
    model_op(op, a, b, res);
    lat = (op == 4'd10) ? W + 1 : 1;
`ifdef SEQ_ALU_DIV_EN
    if (op == 4'd11 && b != 0) lat = W + 1;
`endif
    @(posedge Clk);
    #1;
    n = cyc;
    exp_q.push_back({32'(n + lat), res, (res == '0), m_hi, m_lo});
    @(negedge Clk);
    Start = 1'b0;
    check("busy_after_start", {31'd0, Busy}, 32'd1);
    A = $urandom;
    B = $urandom;
    ALUControl = 4'($urandom_range(0, 15));
  endtask

  // monitor / scoreboard
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=1 with empty queue, ALUResult=%h", ALUResult);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e[EW-1:3*W+1]);
        check("alu_result", ALUResult, e[3*W:2*W+1]);
        check("zero", {31'd0, Zero}, {31'd0, e[2*W]});
        check("hi", Hi, e[2*W-1:W]);
        check("lo", Lo, e[W-1:0]);
        check("busy_at_done", {31'd0, Busy}, 32'd1);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_result"}, ALUResult, 32'd0);
    check({tag, "_zero"}, {31'd0, Zero}, 32'd1);
    check({tag, "_hi"}, Hi, 32'd0);
    check({tag, "_lo"}, Lo, 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b;
    Reset = 1'b1;
    Start = 1'b0;
    ALUControl = '0;
    A = '0;
    B = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge Clk);
    check_reset_state("reset");
    Reset = 1'b0;

    // directed cases
    issue(4'd0, 32'd1, 32'd1);
    issue(4'd1, 32'd3, 32'd3);
    issue(4'd8, 32'hFFFFFFFF, 32'd1);
    issue(4'd9, 32'h80000000, 32'h21);
    issue(4'd9, 32'h80000000, 32'd0);
    issue(4'd6, 32'h00000001, 32'hFFFFFFFF);
    issue(4'd10, 32'hFFFFFFFF, 32'd2);
    issue(4'd12, 32'd5, 32'd6);
    issue(4'd11, 32'd7, 32'd2);
    issue(4'd11, 32'd5, 32'd0);
    issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Start pulsed with add operands mid-multiply must be ignored
    issue(4'd10, 32'h12345678, 32'h9ABCDEF0);
    repeat (4) @(negedge Clk);
    ALUControl = 4'd0;
    A = 32'd1;
    B = 32'd1;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      issue(op, a, b);
    end

    // reset in the middle of a multiply discards it
    issue(4'd10, $urandom, $urandom);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_state("midreset");
    Reset = 1'b0;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (W + 6) @(negedge Clk);

    issue(4'd5, 32'hA5A5A5A5, 32'hFFFF0000);
    issue(4'd4, 32'd0, 32'd0);

    wait_idle();
    repeat (3) @(negedge Clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
